// File: rtl/hwpe_ctrl_periph_target.sv
// Periph-bus target in front of the HWPE control register file: control words, job FSM,
// and forwarding of all other words to the regfile read/write ports.
// Optional error response port enabled by defining HWPE_CTRL_TARGET_ERR_EN.
module hwpe_ctrl_periph_target #(
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ID_WIDTH       = 8,
   parameter int unsigned BUS_ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      req,
   input  logic [BUS_ADDR_WIDTH-1:0] add,
   input  logic                      wen,
   input  logic [DATA_WIDTH/8-1:0]   be,
   input  logic [DATA_WIDTH-1:0]     data,
   input  logic [ID_WIDTH-1:0]       id,
   output logic                      gnt,
   output logic [DATA_WIDTH-1:0]     r_data,
   output logic                      r_valid,
   output logic [ID_WIDTH-1:0]       r_id,
`ifdef HWPE_CTRL_TARGET_ERR_EN
   output logic                      r_err,
`endif
   output logic                      rf_read_enable,
   output logic [ADDR_WIDTH-1:0]     rf_read_addr,
   input  logic [DATA_WIDTH-1:0]     rf_read_data,
   output logic                      rf_write_enable,
   output logic [ADDR_WIDTH-1:0]     rf_write_addr,
   output logic [DATA_WIDTH-1:0]     rf_write_data,
   output logic [DATA_WIDTH/8-1:0]   rf_write_be,
   input  logic                      done_i,
   output logic                      start_o,
   output logic                      soft_clear_o,
   output logic                      busy_o
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StStart   = 2'd1;
   localparam logic [1:0] StRunning = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
   logic                  valid_q, rd_q, ctrl_q, sclr_q, err_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] idx_q;

   logic [ADDR_WIDTH-1:0] word;
   logic                  is_ctrl, live, stall, xfer, wr_ok, acc_err;
   logic                  trig, sclr, done_acc;
   logic [DATA_WIDTH-1:0] ctrl_val;
   logic                  unused_add;

   assign word    = add[ADDR_WIDTH+1:2];
   assign is_ctrl = (word < ADDR_WIDTH'(4));
   assign busy_o  = (state_q != StIdle);
   assign live    = rst_n & ~clear;
   // Regfile writes must not race a running job; control traffic always passes.
   assign stall   = ~wen & ~is_ctrl & busy_o;
   assign gnt     = req & live & ~stall;
   assign xfer    = req & gnt;

`ifdef HWPE_CTRL_TARGET_ERR_EN
   assign acc_err = (|add[1:0]) |
                    (~wen & ((word == ADDR_WIDTH'(1)) | (word == ADDR_WIDTH'(3))));
   assign r_err   = valid_q & err_q;
`else
   assign acc_err = 1'b0;
`endif
   assign unused_add = ^{add[BUS_ADDR_WIDTH-1:ADDR_WIDTH+2], add[1:0]};

   assign wr_ok    = xfer & ~wen & ~acc_err;
   assign trig     = wr_ok & (word == ADDR_WIDTH'(0));
   assign sclr     = wr_ok & (word == ADDR_WIDTH'(2));
   assign done_acc = (state_q == StRunning) & done_i;

   assign rf_read_enable  = xfer & wen;
   assign rf_read_addr    = word;
   assign rf_write_enable = wr_ok & ~is_ctrl;
   assign rf_write_addr   = word;
   assign rf_write_data   = data;
   assign rf_write_be     = be;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (trig) state_d = StStart;
         StStart:   state_d = StRunning;
         StRunning: if (done_i) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      if (sclr) state_d = StIdle;
      cnt_d = cnt_q + DATA_WIDTH'(done_acc);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         sclr_q  <= 1'b0;
         id_q    <= '0;
         idx_q   <= '0;
         ctrl_q  <= 1'b0;
         rd_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= xfer;
         sclr_q  <= sclr;
         if (xfer) begin
            id_q   <= id;
            idx_q  <= word;
            ctrl_q <= is_ctrl;
            rd_q   <= wen;
            err_q  <= acc_err;
         end
      end
   end

   // Control reads reflect live state at response time, not at request time.
   always_comb begin
      ctrl_val = '0;
      case (idx_q)
         ADDR_WIDTH'(1): ctrl_val = DATA_WIDTH'(busy_o);
         ADDR_WIDTH'(3): ctrl_val = cnt_q;
         default:        ctrl_val = '0;
      endcase
   end

   assign r_data       = (valid_q & rd_q) ? (ctrl_q ? ctrl_val : rf_read_data) : '0;
   assign r_valid      = valid_q;
   assign r_id         = id_q;
   assign start_o      = (state_q == StStart);
   assign soft_clear_o = sclr_q;

endmodule
